// File: rtl/hack_pkg.sv
// Shared definitions for the fetch-path program counter: default word width
// and the encoding of the next-PC select.
package hack_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] NS_HOLD = 3'd0;
  localparam logic [2:0] NS_INC  = 3'd1;
  localparam logic [2:0] NS_LOAD = 3'd2;
  localparam logic [2:0] NS_CALL = 3'd3;
  localparam logic [2:0] NS_RET  = 3'd4;
  localparam logic [2:0] NS_TRAP = 3'd5;

endpackage

// File: rtl/pc_call_stack_if.sv
// Control/status bundle between the fetch sequencer (master) and the
// program counter with return stack (slave).
interface pc_call_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output in, load, inc, call, ret,
    input  out, depth, empty, full, err
  );

  modport slave (
    input  in, load, inc, call, ret,
    output out, depth, empty, full, err
  );
endinterface

// File: rtl/pc_call_stack_ret_stack.sv
// Return-address LIFO: register-array storage with an occupancy counter.
// A push when full and a pop when empty are ignored; if both arrive in the
// same cycle, the pop wins. top is a combinational read of the newest entry.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DW-1:0]               cnt;
  logic [AW-1:0]               wr_idx;
  logic [AW-1:0]               rd_idx;

  assign wr_idx = AW'(cnt);
  assign rd_idx = AW'(cnt - DW'(1));
  assign empty  = (cnt == DW'(0));
  assign full   = (cnt == DW'(DEPTH));
  assign depth  = cnt;
  assign top    = empty ? '0 : mem[rd_idx];

  // Occupancy counter; entries themselves carry no reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end
  end

  // Entry write at the current fill level.
  always_ff @(posedge clk) begin
    if (reset_n && push && !pop && !full) begin
      mem[wr_idx] <= wdata;
    end
  end
endmodule

// File: rtl/pc_call_stack.sv
// Program counter with integrated return-address stack.
// Priority ret > call > load > inc > hold; one action per cycle.
// Optional macro PC_TRAP_EN: stack overflow/underflow forces out to TRAP_ADDR.
module pc_call_stack
  import hack_pkg::*;
#(
  parameter int                WIDTH     = WORD_W,
  parameter int                DEPTH     = 8,
  parameter logic [WIDTH-1:0]  TRAP_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pc_call_stack_if.slave       bus
);
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] top;
  logic [2:0]       sel;
  logic             push;
  logic             pop;
  logic             err;
  logic             err_set;
  logic             st_full;
  logic             st_empty;

  assign pc_inc  = pc + WIDTH'(1);
  assign bus.out = pc;
  assign bus.err = err;
  assign bus.full  = st_full;
  assign bus.empty = st_empty;

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (pc_inc),
    .top     (top),
    .depth   (bus.depth),
    .full    (st_full),
    .empty   (st_empty)
  );

  // Priority encode the request into a next-PC select and stack strobes.
  always_comb begin
    sel     = NS_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.ret) begin
      if (st_empty) begin
        err_set = 1'b1;
`ifdef PC_TRAP_EN
        sel     = NS_TRAP;
`else
        sel     = NS_HOLD;
`endif
      end else begin
        pop = 1'b1;
        sel = NS_RET;
      end
    end else if (bus.call) begin
      if (st_full) begin
        err_set = 1'b1;
`ifdef PC_TRAP_EN
        sel     = NS_TRAP;
`else
        sel     = NS_CALL;
`endif
      end else begin
        push = 1'b1;
        sel  = NS_CALL;
      end
    end else if (bus.load) begin
      sel = NS_LOAD;
    end else if (bus.inc) begin
      sel = NS_INC;
    end
  end

  // Next-PC mux.
  always_comb begin
    pc_nxt = pc;
    case (sel)
      NS_INC:  pc_nxt = pc_inc;
      NS_LOAD: pc_nxt = bus.in;
      NS_CALL: pc_nxt = bus.in;
      NS_RET:  pc_nxt = top;
      NS_TRAP: pc_nxt = TRAP_ADDR;
      default: pc_nxt = pc;
    endcase
  end

  // PC register and sticky fault flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc  <= '0;
      err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (err_set) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack (WIDTH=16, DEPTH=4): directed
// scenarios followed by random traffic, all against a queue-based model.
module tb_pc_call_stack;
  localparam int          W    = 16;
  localparam int          D    = 4;
  localparam logic [15:0] TRAP = 16'h7FF0;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_err;

  pc_call_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pc_call_stack #(.WIDTH(W), .DEPTH(D), .TRAP_ADDR(TRAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one sampled edge using the spec's rules.
  task automatic model(input logic rn, input logic [15:0] in, input logic ld,
                       input logic ic, input logic cl, input logic rt);
    bit trap_en = 1'b0;
`ifdef PC_TRAP_EN
    trap_en = 1'b1;
`endif
    if (!rn) begin
      m_pc = 16'h0000; m_stk.delete(); m_err = 1'b0;
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_err = 1'b1; if (trap_en) m_pc = TRAP; end
    end else if (cl) begin
      if (m_stk.size() < D) begin m_stk.push_back(m_pc + 16'd1); m_pc = in; end
      else begin m_err = 1'b1; m_pc = trap_en ? TRAP : in; end
    end else if (ld) m_pc = in;
    else if (ic) m_pc = m_pc + 16'd1;
  endtask

  task automatic step(input string tag, input logic rn, input logic [15:0] in,
                      input logic ld, input logic ic, input logic cl, input logic rt);
    @(negedge clk);
    reset_n = rn; bus.in = in; bus.load = ld; bus.inc = ic; bus.call = cl; bus.ret = rt;
    @(posedge clk);
    model(rn, in, ld, ic, cl, rt);
    #1;
    chk({tag, ".out"},   32'(bus.out),   32'(m_pc));
    chk({tag, ".depth"}, 32'(bus.depth), 32'(m_stk.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(m_stk.size() == 0));
    chk({tag, ".full"},  32'(bus.full),  32'(m_stk.size() == D));
    chk({tag, ".err"},   32'(bus.err),   32'(m_err));
  endtask

  initial begin
    reset_n = 1'b0;
    bus.in = '0; bus.load = 0; bus.inc = 0; bus.call = 0; bus.ret = 0;
    m_pc = '0; m_err = 1'b0;

    // Reset overrides a simultaneous call.
    step("rst_call", 0, 16'h0040, 0, 0, 1, 0);
    chk("rst_out_const", 32'(bus.out), 32'h0);

    // Single call/ret pair.
    step("ld10", 1, 16'h0010, 1, 0, 0, 0);
    step("call100", 1, 16'h0100, 0, 0, 1, 0);
    chk("call100_const", 32'(bus.out), 32'h0100);
    step("ret11", 1, 16'h0000, 0, 0, 0, 1);
    chk("ret11_const", 32'(bus.out), 32'h0011);

    // Fill the stack, overflow, then unwind in LIFO order.
    for (int i = 0; i < 4; i++) step("nest", 1, 16'h0200 + 16'(i), 0, 0, 1, 0);
    chk("full_const", 32'(bus.full), 32'h1);
    step("ovf", 1, 16'h0300, 0, 0, 1, 0);
    chk("ovf_err_const", 32'(bus.err), 32'h1);
    for (int i = 0; i < 4; i++) step("unwind", 1, 16'h0000, 0, 0, 0, 1);

    // Underflow after a fresh reset.
    step("rst2", 0, 16'h0000, 0, 0, 0, 0);
    step("ld55", 1, 16'h0055, 1, 0, 0, 0);
    step("unf", 1, 16'h0000, 0, 0, 0, 1);
    chk("unf_err_const", 32'(bus.err), 32'h1);

    // Wrap on inc and on pushed return address.
    step("rst3", 0, 16'h0000, 0, 0, 0, 0);
    step("ldffff", 1, 16'hFFFF, 1, 0, 0, 0);
    step("incwrap", 1, 16'h0000, 0, 1, 0, 0);
    chk("incwrap_const", 32'(bus.out), 32'h0);
    step("ldffff2", 1, 16'hFFFF, 1, 0, 0, 0);
    step("callwrap", 1, 16'h0005, 0, 0, 1, 0);
    step("retwrap", 1, 16'h0000, 0, 0, 0, 1);
    chk("retwrap_const", 32'(bus.out), 32'h0);

    // All requests at once with depth 1: only the pop happens.
    step("ld20", 1, 16'h0020, 1, 0, 0, 0);
    step("call1", 1, 16'h0400, 0, 0, 1, 0);
    step("allreq", 1, 16'h0777, 1, 1, 1, 1);
    chk("allreq_out_const", 32'(bus.out), 32'h0021);

    // Random traffic, weighted toward calls and rets, with rare resets.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] r_in;
      logic rn, ld, ic, cl, rt;
      r_in = 16'($urandom);
      if ($urandom_range(0, 9) == 0) r_in = 16'hFFFF;
      rn = ($urandom_range(0, 59) != 0);
      ld = ($urandom_range(0, 5) == 0);
      ic = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 3) == 0);
      step("rand", rn, r_in, ld, ic, cl, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
